seven_seg_scan_ctrl: RTL
========================

Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode seven-segment digits that share one hex-to-seven-segment decoder. It holds the displayed hex value and feeds one nibble at a time to the shared decoder. It drives the active-low digit anodes in rotation, with a blanking gap at every digit change to prevent ghosting. New display values arrive over a valid/ready handshake and are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal 1..8
REFRESH_DIV, 50000, clk cycles each digit is lit per frame; >=1
BLANK_CYCLES, 16, clk cycles with all anodes off before each digit; >=1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
load_valid  in  1  load_data is valid
load_ready  out  1  controller can accept a value
load_data  in  4*NUM_DIGITS  new value; nibble i goes to digit i (digit 0 = LS nibble)
digit_en  in  NUM_DIGITS  per-digit enable mask; sampled every cycle
hex_sel  out  4  nibble sent to the shared decoder
an_n  out  NUM_DIGITS  active-low anode enables; at most one bit low
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (reset==0 at posedge):
  - state=BLANK, digit_idx=0, counters=0.
  - display register=0, pending=0.
  - an_n=all ones, hex_sel=0, frame_tick=0, load_ready=0.
- All outputs are registered.
- load_ready = ~pending once reset is released.
- Accept: load_valid && load_ready at a posedge -> pending_data<=load_data, pending<=1.
- While pending==1, load_ready=0 and load_valid is ignored.
- FSM states: BLANK, SCAN.
- BLANK:
  - an_n=all ones; hex_sel already shows display nibble digit_idx.
  - Lasts exactly BLANK_CYCLES cycles, then goes to SCAN.
- SCAN:
  - an_n[digit_idx]=0 if digit_en[digit_idx]==1, else all ones.
  - A disabled digit still uses its full slot, so brightness stays constant.
  - Lasts exactly REFRESH_DIV cycles, then goes to BLANK.
  - On that transition, digit_idx advances, wrapping NUM_DIGITS-1 -> 0.
  - hex_sel is updated to the new digit's nibble in the same cycle.
- Frame boundary = leaving SCAN of digit NUM_DIGITS-1. On that cycle:
  - frame_tick=1 for one cycle.
  - If pending: display<=pending_data, pending<=0.
  - hex_sel for digit 0 uses the newly committed value.
- Commit and accept in the same cycle cannot happen (ready=0 while pending). load_ready returns to 1 the cycle after commit.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
- Latency:
  - First anode goes low BLANK_CYCLES cycles after the first posedge with reset==1.
  - A loaded value is visible on hex_sel from the next frame boundary.
- Counter widths are sized with $clog2 of the larger of REFRESH_DIV and BLANK_CYCLES. No overflow is permitted.
- Reset mid-scan: all outputs return to reset values on the next posedge. Pending data is discarded.
- NUM_DIGITS==1: every SCAN exit is a frame boundary, and digit_idx stays 0.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: during SCAN, an_n stays all ones for every digit above the most significant nonzero nibble of the display register. Digit 0 is always lit (subject to digit_en). This is evaluated on the committed display value only.
- Undefined: all enabled digits are lit regardless of value.

Test Plan:
All tests use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2.
- Reset: hold reset=0 for 3 cycles -> an_n=4'b1111, hex_sel=0, load_ready=0, frame_tick=0. Release -> load_ready=1, an_n=4'b1111 for 2 cycles, then an_n=4'b1110 for 4 cycles.
- Scan order: load 16'h4321 in frame 0 -> from the next frame, hex_sel=1,2,3,4 with an_n=1110,1101,1011,0111. Each digit lit 4 cycles with 2 blank cycles before it. frame_tick period = 24 cycles.
- Handshake: load 16'hABCD, then hold load_valid=1 with 16'h1111 -> load_ready=0 until the boundary. ABCD is displayed in the next frame. 1111 is accepted the cycle after the commit and displayed one frame later.
- Mask: digit_en=4'b1010 with display 16'h4321 -> an_n stays 1111 in the slots for digits 0 and 2. Frame period is still 24 cycles.
- Reset mid-operation: assert reset during SCAN of digit 2 with pending=1 -> next cycle an_n=1111, pending cleared. After release the display shows 0000.
- LEADING_ZERO_BLANK_EN defined, display 16'h0050 -> only digits 0 and 1 are lit. Display 16'h0000 -> only digit 0 is lit, with hex_sel=0.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits sharing one decoder.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   output logic [3:0]              hex_sel,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_tick
);

   localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {
      ST_BLANK,
      ST_SCAN
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] display_q, display_d;
   logic [4*NUM_DIGITS-1:0] pending_data_q, pending_data_d;
   logic                    pending_q, pending_d;
   logic [3:0]              hex_sel_q, hex_sel_d;
   logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
   logic                    frame_tick_q, frame_tick_d;
   logic                    load_ready_q, load_ready_d;
   logic                    frame_end;
   logic                    accept;
   logic [NUM_DIGITS-1:0]   lit_mask;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_BLANK;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state logic; frame_end marks the exit from the last digit's SCAN slot
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      idx_d     = idx_q;
      frame_end = 1'b0;
      case (state_q)
         ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = ST_SCAN;
               cnt_d   = '0;
            end
         end
         ST_SCAN: begin
            if (cnt_q == SCAN_LAST) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d     = '0;
                  frame_end = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_BLANK;
         end
      endcase
   end

   // Load handshake and frame-aligned commit; ready is derived from the next pending value
   always_comb begin
      accept         = load_valid && load_ready_q;
      pending_d      = pending_q;
      pending_data_d = pending_data_q;
      display_d      = display_q;
      if (frame_end && pending_q) begin
         display_d = pending_data_q;
         pending_d = 1'b0;
      end
      if (accept) begin
         pending_data_d = load_data;
         pending_d      = 1'b1;
      end
      load_ready_d = ~pending_d;
   end

`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      lit_mask = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         lit_mask[i] = (i == 0) || (|(display_q >> (4 * i)));
      end
   end
`else
   always_comb begin
      lit_mask = '1;
   end
`endif

   // Output logic: registered outputs follow the current state one cycle later
   always_comb begin
      hex_sel_d    = '0;
      an_n_d       = '1;
      frame_tick_d = frame_end;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            hex_sel_d = display_q[4*i +: 4];
            if (state_q == ST_SCAN && digit_en[i] && lit_mask[i]) begin
               an_n_d[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         display_q      <= '0;
         pending_data_q <= '0;
         pending_q      <= 1'b0;
         hex_sel_q      <= '0;
         an_n_q         <= '1;
         frame_tick_q   <= 1'b0;
         load_ready_q   <= 1'b0;
      end else begin
         display_q      <= display_d;
         pending_data_q <= pending_data_d;
         pending_q      <= pending_d;
         hex_sel_q      <= hex_sel_d;
         an_n_q         <= an_n_d;
         frame_tick_q   <= frame_tick_d;
         load_ready_q   <= load_ready_d;
      end
   end

   assign load_ready = load_ready_q;
   assign hex_sel    = hex_sel_q;
   assign an_n       = an_n_q;
   assign frame_tick = frame_tick_q;

endmodule
